status_flags: RTL
=================

STATUS_FLAGS -- requirements
Module: status_flags

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the ALU result width.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, the flag save-stack entries; power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state rises on its posedge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port alu_result, input, DATA_W, the ALU result to evaluate.
REQ-006 SHALL have port alu_carry, input, 1, the ALU carry-out.
REQ-007 SHALL have port flag_we, input, 1, the flag update strobe.
REQ-008 SHALL have port flag_mask, input, 3, the per-flag update enable, with bit index equal to status index.
REQ-009 SHALL have port push, input, 1, which saves status to the stack.
REQ-010 SHALL have port pop, input, 1, which restores status from the stack.
REQ-011 SHALL have port status, output, 3, the registered flags: [0] Zero, [1] Negative, [2] Carry. It feeds the jump decision logic.
REQ-012 SHALL have port stack_full, output, 1, asserted when STACK_DEPTH entries are held.
REQ-013 SHALL have port stack_empty, output, 1, asserted when 0 entries are held.
REQ-014 SHALL have port stack_err, output, 1, a one-cycle registered pulse flagging an illegal stack request.

Function
REQ-015 SHALL, on a flag_we cycle, compute Z = (alu_result == 0), N = alu_result[DATA_W-1], and C = alu_carry.
REQ-016 SHALL update only those status bits whose flag_mask bit is 1; unmasked bits hold.
REQ-017 SHALL make an updated status visible one cycle after the flag_we edge, with no combinational path from inputs to status.
REQ-018 SHALL, on push when not full, write the pre-edge status to the top of stack and increment the count by 1.
REQ-019 SHALL, on pop when not empty, load status from the top of stack and decrement the count by 1.
REQ-020 SHALL give pop priority over flag_we in the same cycle: the restored value wins and flag_we is ignored.
REQ-021 SHALL, when push and flag_we occur in the same cycle, push the old status and then apply the masked update to status.
REQ-022 SHALL treat push and pop in the same cycle as illegal: no stack or status change, and stack_err pulses.
REQ-023 SHALL treat push when full as illegal: no change, and stack_err pulses; flag_we is still honoured that cycle.
REQ-024 SHALL treat pop when empty as illegal: no change, and stack_err pulses; flag_we is still honoured that cycle.
REQ-025 SHALL derive stack_full and stack_empty from the registered count, updated on the cycle after the edge.
REQ-026 SHALL contain no stack-pointer wrap-around; the count saturates, guarded by REQ-023 and REQ-024.

Reset
REQ-027 SHALL, on rst assertion, asynchronously clear status to 000, count to 0, and stack_err to 0, and set stack_empty=1 and stack_full=0.
REQ-028 SHALL abandon any in-flight push or pop on a reset asserted mid-operation; stack contents need not be cleared.
REQ-029 SHALL release reset on the clk edge and give the first functional update on the next posedge.

Configuration
REQ-030 SHALL compile the stack and the push, pop, stack_full, stack_empty and stack_err logic only under the macro FLAG_STACK_EN.
REQ-031 SHALL, without FLAG_STACK_EN, ignore push and pop, tie stack_full=0, stack_empty=1 and stack_err=0, and keep the flag update behaviour unchanged.

Structure
REQ-032 SHALL place the constants ZERO_IDX=0, NEG_IDX=1, CARRY_IDX=2 and STATUS_W=3 in the shared package, also used by the jump decision logic.
REQ-033 SHALL implement the LIFO storage and count as sub-module flag_stack, instantiated only under FLAG_STACK_EN.

Verification
REQ-034 SHALL verify reset: assert rst mid-cycle after loading status=111 -> status=000, stack_empty=1 immediately, without waiting for a clock edge.
REQ-035 SHALL verify flag update: flag_we=1, mask=111, alu_result=8'h80, carry=1 -> status=110 on the next cycle; then alu_result=0 with mask=001 -> status=111.
REQ-036 SHALL verify push/pop round trip: set status=101, push, update to 010, pop -> status=101, stack_empty=1.
REQ-037 SHALL verify overflow: push 4 times -> stack_full=1; a 5th push -> stack_err pulses for 1 cycle and the count stays at 4.
REQ-038 SHALL verify underflow and conflict: pop when empty -> stack_err=1 and status unchanged; push+pop together -> stack_err=1 and no state change.
REQ-039 SHALL verify priority: pop with flag_we=1 (result 0) -> status equals the popped value, not Z=1.

Source files
------------

// File: rtl/status_flags_pkg.sv
// Shared status-flag definitions, used by status_flags and the jump decision logic.
package status_flags_pkg;

  localparam int unsigned ZERO_IDX  = 0;
  localparam int unsigned NEG_IDX   = 1;
  localparam int unsigned CARRY_IDX = 2;
  localparam int unsigned STATUS_W  = 3;

  typedef enum logic [1:0] {
    STK_IDLE,
    STK_PUSH,
    STK_POP,
    STK_ILLEGAL
  } stk_op_e;

  // Push and pop together, push when full, or pop when empty are all rejected.
  function automatic stk_op_e decode_stk_op(input logic push, input logic pop,
                                            input logic full, input logic empty);
    stk_op_e op;
    if (push && pop)  op = STK_ILLEGAL;
    else if (push)    op = full  ? STK_ILLEGAL : STK_PUSH;
    else if (pop)     op = empty ? STK_ILLEGAL : STK_POP;
    else              op = STK_IDLE;
    return op;
  endfunction

endpackage

// File: rtl/status_flags_flag_stack.sv
// LIFO of saved status words with a saturating entry count.
// Callers must only assert push when not full and pop when not empty.
module flag_stack
  import status_flags_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [STATUS_W-1:0] wr_data,
  output logic [STATUS_W-1:0] rd_data,
  output logic                full,
  output logic                empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]    count_q, count_d;
  logic [STATUS_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_idx, top_idx;

  assign wr_idx  = count_q[PTR_W-1:0];
  assign top_idx = PTR_W'(count_q - CNT_W'(1));

  always_comb begin
    count_d = count_q;
    if (push)     count_d = count_q + CNT_W'(1);
    else if (pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Storage is left uncleared by reset; only the count defines validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= wr_data;
  end

  assign rd_data = mem_q[top_idx];
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/status_flags.sv
// Registered Zero/Negative/Carry flags with masked update and optional save stack.
// Define FLAG_STACK_EN to build the push/pop stack; otherwise push/pop are ignored.
module status_flags
  import status_flags_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_carry,
  input  logic                flag_we,
  input  logic [STATUS_W-1:0] flag_mask,
  input  logic                push,
  input  logic                pop,
  output logic [STATUS_W-1:0] status,
  output logic                stack_full,
  output logic                stack_empty,
  output logic                stack_err
);

  logic [STATUS_W-1:0] status_q, status_d;
  logic [STATUS_W-1:0] alu_flags, upd_flags;

  always_comb begin
    alu_flags            = '0;
    alu_flags[ZERO_IDX]  = (alu_result == '0);
    alu_flags[NEG_IDX]   = alu_result[DATA_W-1];
    alu_flags[CARRY_IDX] = alu_carry;
  end

  always_comb begin
    upd_flags = status_q;
    for (int unsigned i = 0; i < STATUS_W; i++) begin
      if (flag_we && flag_mask[i]) upd_flags[i] = alu_flags[i];
    end
  end

`ifdef FLAG_STACK_EN
  stk_op_e             stk_op;
  logic                stk_full, stk_empty;
  logic [STATUS_W-1:0] pop_data;
  logic                stack_err_q, stack_err_d;

  // A restore overrides the flag update; a push+pop conflict freezes status,
  // while other rejected requests still let the flag update through.
  always_comb begin
    stk_op      = decode_stk_op(push, pop, stk_full, stk_empty);
    status_d    = upd_flags;
    stack_err_d = 1'b0;
    case (stk_op)
      STK_POP: status_d = pop_data;
      STK_ILLEGAL: begin
        stack_err_d = 1'b1;
        if (push && pop) status_d = status_q;
      end
      default: ;
    endcase
  end

  flag_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_flag_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (stk_op == STK_PUSH),
    .pop     (stk_op == STK_POP),
    .wr_data (status_q),
    .rd_data (pop_data),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stack_err_q <= 1'b0;
    else     stack_err_q <= stack_err_d;
  end

  assign stack_full  = stk_full;
  assign stack_empty = stk_empty;
  assign stack_err   = stack_err_q;
`else
  logic unused_stack_req;

  always_comb begin
    status_d = upd_flags;
  end

  assign unused_stack_req = push ^ pop;
  assign stack_full       = 1'b0;
  assign stack_empty      = 1'b1;
  assign stack_err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) status_q <= '0;
    else     status_q <= status_d;
  end

  assign status = status_q;

endmodule
